noc_depacketizer: RTL and testbench
===================================

Name: noc_depacketizer

Overview:
- Receive-side network interface: consumes the flit stream leaving a router's local port and turns it back into a word stream for the attached core.
- Checks the header destination against the local node address and latches the header's tail_length.
- Emits DATA/TAIL payloads as words, with a last flag and a valid-bit count on the final word.
- Drops misrouted packets and malformed flits, and flags both.

Parameters:
- FLIT_DATA_WIDTH, 32, payload bits per flit; flit width = FLIT_DATA_WIDTH+2.
- MESH_ADDR_X, 2, bits of X coordinate.
- MESH_ADDR_Y, 2, bits of Y coordinate.
- TAIL_LEN_W, 6, width of tail_length; must hold FLIT_DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- local_x  in  MESH_ADDR_X  this node's X; quasi-static.
- local_y  in  MESH_ADDR_Y  this node's Y; quasi-static.
- in_flit  in  FLIT_DATA_WIDTH+2  flit; [MSB:MSB-1] = type (0 HEADER, 1 DATA, 2 TAIL, 3 reserved), lower bits = payload.
- in_valid  in  1  flit present.
- in_ready  out  1  flit accepted when in_valid&&in_ready.
- out_data  out  FLIT_DATA_WIDTH  word payload.
- out_bits  out  TAIL_LEN_W  valid LSBs of out_data.
- out_last  out  1  final word of packet.
- out_valid  out  1  word present.
- out_ready  in  1  consumer accepts word.
- err_misroute  out  1  one-cycle pulse: header dst != local address.
- err_proto  out  1  one-cycle pulse: flit illegal in current state.

Behaviour:
- Header payload layout: [TAIL_LEN_W-1:0] = tail_length; [TAIL_LEN_W+MESH_ADDR_Y-1:TAIL_LEN_W] = dst y; next MESH_ADDR_X bits = dst x; remaining bits ignored.
- Reset state: IDLE. out_valid=0, out_data=0, out_bits=0, out_last=0, err_*=0, latched tail_len=0.
- Reset mid-packet discards the partial packet; the next accepted flit must be a HEADER.
- State IDLE, in_ready=1:
  - HEADER with dst=={local_x,local_y}: latch tail_length -> BODY.
  - HEADER with a mismatched dst: err_misroute pulse -> DROP.
  - DATA/TAIL/reserved: flit discarded, err_proto pulse, stay IDLE.
- State BODY, in_ready = !out_valid || out_ready (single output register, no bubbles):
  - DATA: register payload, out_bits=FLIT_DATA_WIDTH, out_last=0.
  - TAIL: register payload masked to tail_len LSBs (upper bits zeroed), out_bits=tail_len, out_last=1 -> IDLE.
  - tail_len=0 still emits one beat with out_bits=0, out_data=0, out_last=1.
  - HEADER/reserved: flit consumed and discarded, err_proto pulse, stay BODY.
- State DROP, in_ready=1: discard all flits.
  - TAIL -> IDLE.
  - HEADER/reserved in DROP: err_proto pulse, stay DROP.
- Latency: flit accepted at cycle N appears on out_* at N+1. Headers produce no output beat.
- Output register holds while out_valid&&!out_ready; out_valid drops after a handshake with no new flit.
- Back-to-back: TAIL accepted at N and HEADER accepted at N+1 is legal; full throughput is 1 flit/cycle with out_ready=1.
- err_* are registered, asserted the cycle after the offending flit is accepted.

Optional Feature:
- Macro NOC_DEPKT_STATS_EN. When defined, adds outputs:
  - rx_pkt_count (16 bits): increments when an out_last beat handshakes.
  - drop_pkt_count (16 bits): increments on each misrouted header.
  - Both wrap at 2^16 and reset to 0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- local=(1,2); HEADER dst(1,2) tail_len=8; DATA 0xDEADBEEF; TAIL 0xFFFFFFA5; out_ready=1 -> beats {0xDEADBEEF, bits 32, last 0} then {0x000000A5, bits 8, last 1}, one cycle after each flit.
- local=(1,2); HEADER dst(3,0), DATA x2, TAIL; then a valid packet -> err_misroute one pulse, no output for the first packet, second packet delivered intact.
- DATA flit in IDLE, then HEADER inside BODY -> err_proto pulse for each, no output beat, BODY packet still completes on its TAIL.
- out_ready held 0 for 5 cycles mid-packet -> in_ready=0 after the first buffered word; out_data stable; no flit lost or duplicated on release.
- HEADER tail_len=0 then TAIL -> single beat out_bits=0, out_data=0, out_last=1.
- Assert rst during BODY after 1 DATA -> outputs 0 asynchronously; a following TAIL raises err_proto; the next full packet is delivered correctly (with NOC_DEPKT_STATS_EN: rx_pkt_count=1).

Source files
------------

// File: rtl/noc_depacketizer.sv
// rtl/noc_depacketizer.sv - NoC receive-side depacketizer: flit stream to word stream; NOC_DEPKT_STATS_EN adds packet counters
module noc_depacketizer #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int MESH_ADDR_X     = 2,
    parameter int MESH_ADDR_Y     = 2,
    parameter int TAIL_LEN_W      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MESH_ADDR_X-1:0]     local_x,
    input  logic [MESH_ADDR_Y-1:0]     local_y,
    input  logic [FLIT_DATA_WIDTH+1:0] in_flit,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
    output logic [TAIL_LEN_W-1:0]      out_bits,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_misroute,
    output logic                       err_proto
`ifdef NOC_DEPKT_STATS_EN
    ,
    output logic [15:0]                rx_pkt_count,
    output logic [15:0]                drop_pkt_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

    localparam logic [1:0] T_HEADER = 2'd0;
    localparam logic [1:0] T_DATA   = 2'd1;
    localparam logic [1:0] T_TAIL   = 2'd2;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [TAIL_LEN_W-1:0]      r_tail_len;
    logic [FLIT_DATA_WIDTH-1:0] r_out_data;
    logic [TAIL_LEN_W-1:0]      r_out_bits;
    logic                       r_out_last;
    logic                       r_out_valid;
    logic                       r_err_misroute;
    logic                       r_err_proto;

    logic [1:0]                 w_type;
    logic [FLIT_DATA_WIDTH-1:0] w_payload;
    logic [TAIL_LEN_W-1:0]      w_hdr_tail;
    logic [MESH_ADDR_Y-1:0]     w_dst_y;
    logic [MESH_ADDR_X-1:0]     w_dst_x;
    logic                       w_dst_match;
    logic                       w_body_ready;
    logic [FLIT_DATA_WIDTH-1:0] w_mask;
    logic                       w_load_beat;
    logic                       w_beat_last;
    logic                       w_latch_hdr;
    logic                       w_misroute;
    logic                       w_proto;

    assign w_type       = in_flit[FLIT_DATA_WIDTH+1:FLIT_DATA_WIDTH];
    assign w_payload    = in_flit[FLIT_DATA_WIDTH-1:0];
    assign w_hdr_tail   = w_payload[TAIL_LEN_W-1:0];
    assign w_dst_y      = w_payload[TAIL_LEN_W+MESH_ADDR_Y-1:TAIL_LEN_W];
    assign w_dst_x      = w_payload[TAIL_LEN_W+MESH_ADDR_Y+MESH_ADDR_X-1:TAIL_LEN_W+MESH_ADDR_Y];
    assign w_dst_match  = (w_dst_x == local_x) && (w_dst_y == local_y);
    // Single output register: a new word may enter only if the current one leaves this cycle.
    assign w_body_ready = !r_out_valid || out_ready;
    assign w_mask       = (r_tail_len >= TAIL_LEN_W'(FLIT_DATA_WIDTH)) ? {FLIT_DATA_WIDTH{1'b1}}
                                                                      : ~({FLIT_DATA_WIDTH{1'b1}} << r_tail_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b1;
        w_load_beat  = 1'b0;
        w_beat_last  = 1'b0;
        w_latch_hdr  = 1'b0;
        w_misroute   = 1'b0;
        w_proto      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_type == T_HEADER) begin
                        if (w_dst_match) begin
                            w_latch_hdr  = 1'b1;
                            w_state_next = S_BODY;
                        end else begin
                            w_misroute   = 1'b1;
                            w_state_next = S_DROP;
                        end
                    end else begin
                        w_proto = 1'b1;
                    end
                end
            end
            S_BODY: begin
                in_ready = w_body_ready;
                if (in_valid && w_body_ready) begin
                    if (w_type == T_DATA) begin
                        w_load_beat = 1'b1;
                    end else if (w_type == T_TAIL) begin
                        w_load_beat  = 1'b1;
                        w_beat_last  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_proto = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (in_valid) begin
                    if (w_type == T_TAIL)      w_state_next = S_IDLE;
                    else if (w_type != T_DATA) w_proto = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail_len     <= '0;
            r_out_data     <= '0;
            r_out_bits     <= '0;
            r_out_last     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_err_misroute <= 1'b0;
            r_err_proto    <= 1'b0;
        end else begin
            r_err_misroute <= w_misroute;
            r_err_proto    <= w_proto;
            if (w_latch_hdr) r_tail_len <= w_hdr_tail;
            if (w_load_beat) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat_last ? (w_payload & w_mask) : w_payload;
                r_out_bits  <= w_beat_last ? r_tail_len : TAIL_LEN_W'(FLIT_DATA_WIDTH);
                r_out_last  <= w_beat_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef NOC_DEPKT_STATS_EN
    logic [15:0] r_rx_pkt_count;
    logic [15:0] r_drop_pkt_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_pkt_count   <= '0;
            r_drop_pkt_count <= '0;
        end else begin
            if (r_out_valid && out_ready && r_out_last) r_rx_pkt_count <= r_rx_pkt_count + 16'd1;
            if (w_misroute) r_drop_pkt_count <= r_drop_pkt_count + 16'd1;
        end
    end

    assign rx_pkt_count   = r_rx_pkt_count;
    assign drop_pkt_count = r_drop_pkt_count;
`endif

    assign out_data     = r_out_data;
    assign out_bits     = r_out_bits;
    assign out_last     = r_out_last;
    assign out_valid    = r_out_valid;
    assign err_misroute = r_err_misroute;
    assign err_proto    = r_err_proto;

endmodule

// File: tb/tb_noc_depacketizer.sv
// tb/tb_noc_depacketizer.sv - directed self-checking bench for noc_depacketizer
module tb_noc_depacketizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  local_x;
    logic [1:0]  local_y;
    logic [33:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err_misroute;
    logic        err_proto;
`ifdef NOC_DEPKT_STATS_EN
    logic [15:0] rx_pkt_count;
    logic [15:0] drop_pkt_count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] T_HEADER = 2'd0;
    localparam logic [1:0] T_DATA   = 2'd1;
    localparam logic [1:0] T_TAIL   = 2'd2;

    always #5 clk = ~clk;

    noc_depacketizer dut (
        .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_misroute(err_misroute), .err_proto(err_proto)
`ifdef NOC_DEPKT_STATS_EN
        , .rx_pkt_count(rx_pkt_count), .drop_pkt_count(drop_pkt_count)
`endif
    );

    function automatic logic [31:0] hdr(input logic [1:0] dx, input logic [1:0] dy, input logic [5:0] tl);
        return {22'd0, dx, dy, tl};
    endfunction

    task automatic drive(input logic [1:0] t, input logic [31:0] p);
        in_flit  = {t, p};
        in_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1;
        local_x = 2'd1; local_y = 2'd2;
        tick(); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last, err_misroute, err_proto} !== 41'd0) begin
            bad++; $display("FAIL reset_outputs got v=%b d=%h b=%0d l=%b em=%b ep=%b want all 0",
                            out_valid, out_data, out_bits, out_last, err_misroute, err_proto);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd8)); tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_hdr_no_beat got %b want 0", out_valid); end
        drive(T_DATA, 32'hDEADBEEF); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'hDEADBEEF, 6'd32, 1'b0}) begin
            bad++; $display("FAIL basic_data got v=%b d=%h b=%0d l=%b want 1 deadbeef 32 0", out_valid, out_data, out_bits, out_last);
        end
        drive(T_TAIL, 32'hFFFFFFA5); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h000000A5, 6'd8, 1'b1}) begin
            bad++; $display("FAIL basic_tail got v=%b d=%h b=%0d l=%b want 1 000000a5 8 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_misroute;
        int beats;
        beats = 0;
        drive(T_HEADER, hdr(2'd3, 2'd0, 6'd4)); tick();
        total++;
        if ({err_misroute, err_proto, out_valid} !== 3'b100) begin
            bad++; $display("FAIL misroute_pulse got em=%b ep=%b v=%b want 1 0 0", err_misroute, err_proto, out_valid);
        end
        drive(T_DATA, 32'h1); tick(); beats += int'(out_valid);
        total++;
        if (err_misroute !== 1'b0) begin bad++; $display("FAIL misroute_one_pulse got %b want 0", err_misroute); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL drop_in_ready got %b want 1", in_ready); end
        drive(T_DATA, 32'h2); tick(); beats += int'(out_valid);
        drive(T_TAIL, 32'h3); tick(); beats += int'(out_valid);
        total++;
        if (beats != 0 || err_proto !== 1'b0) begin
            bad++; $display("FAIL drop_silent got beats=%0d ep=%b want 0 0", beats, err_proto);
        end
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd16)); tick();
        drive(T_DATA, 32'h12345678); tick();
        total++;
        if ({out_valid, out_data, out_last} !== {1'b1, 32'h12345678, 1'b0}) begin
            bad++; $display("FAIL misroute_next_data got v=%b d=%h l=%b want 1 12345678 0", out_valid, out_data, out_last);
        end
        drive(T_TAIL, 32'hABCD1234); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h00001234, 6'd16, 1'b1}) begin
            bad++; $display("FAIL misroute_next_tail got v=%b d=%h b=%0d l=%b want 1 00001234 16 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_proto;
        drive(T_DATA, 32'h55); tick();
        total++;
        if ({err_proto, out_valid} !== 2'b10) begin
            bad++; $display("FAIL proto_idle_data got ep=%b v=%b want 1 0", err_proto, out_valid);
        end
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd4)); tick();
        total++;
        if ({err_proto, out_valid} !== 2'b00) begin
            bad++; $display("FAIL proto_hdr_ok got ep=%b v=%b want 0 0", err_proto, out_valid);
        end
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd20)); tick();
        total++;
        if ({err_proto, out_valid} !== 2'b10) begin
            bad++; $display("FAIL proto_body_hdr got ep=%b v=%b want 1 0", err_proto, out_valid);
        end
        drive(T_TAIL, 32'hFFFFFFFF); tick();
        total++;
        if ({err_proto, out_valid, out_data, out_bits, out_last} !== {1'b0, 1'b1, 32'h0000000F, 6'd4, 1'b1}) begin
            bad++; $display("FAIL proto_tail got ep=%b v=%b d=%h b=%0d l=%b want 0 1 0000000f 4 1",
                            err_proto, out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_backpressure;
        int stalls_bad;
        stalls_bad = 0;
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd32)); tick();
        out_ready = 1'b0;
        drive(T_DATA, 32'h11111111); tick();
        total++;
        if ({out_valid, out_data, in_ready} !== {1'b1, 32'h11111111, 1'b0}) begin
            bad++; $display("FAIL bp_first got v=%b d=%h rdy=%b want 1 11111111 0", out_valid, out_data, in_ready);
        end
        drive(T_DATA, 32'h22222222);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_data !== 32'h11111111 || out_valid !== 1'b1) stalls_bad++;
        end
        total++;
        if (stalls_bad != 0) begin bad++; $display("FAIL bp_hold got %0d bad cycles want 0", stalls_bad); end
        out_ready = 1'b1; tick();
        total++;
        if ({out_valid, out_data, out_last} !== {1'b1, 32'h22222222, 1'b0}) begin
            bad++; $display("FAIL bp_release got v=%b d=%h l=%b want 1 22222222 0", out_valid, out_data, out_last);
        end
        drive(T_TAIL, 32'h33333333); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h33333333, 6'd32, 1'b1}) begin
            bad++; $display("FAIL bp_tail_full got v=%b d=%h b=%0d l=%b want 1 33333333 32 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_zero_tail;
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd0)); tick();
        drive(T_TAIL, 32'hFFFFFFFF); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h0, 6'd0, 1'b1}) begin
            bad++; $display("FAIL zero_tail got v=%b d=%h b=%0d l=%b want 1 0 0 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_back_to_back;
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd8)); tick();
        drive(T_DATA, 32'h0000000A); tick();
        drive(T_TAIL, 32'h000001FF); tick();
        total++;
        if ({out_data, out_bits, out_last} !== {32'h000000FF, 6'd8, 1'b1}) begin
            bad++; $display("FAIL b2b_tail1 got d=%h b=%0d l=%b want 000000ff 8 1", out_data, out_bits, out_last);
        end
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd12)); tick();
        total++;
        if ({out_valid, err_proto, err_misroute} !== 3'b000) begin
            bad++; $display("FAIL b2b_hdr got v=%b ep=%b em=%b want 0 0 0", out_valid, err_proto, err_misroute);
        end
        drive(T_TAIL, 32'h0FFF0ABC); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h00000ABC, 6'd12, 1'b1}) begin
            bad++; $display("FAIL b2b_tail2 got v=%b d=%h b=%0d l=%b want 1 00000abc 12 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_reset_mid;
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd8)); tick();
        drive(T_DATA, 32'h00000077); tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== 40'd0) begin
            bad++; $display("FAIL async_reset got v=%b d=%h b=%0d l=%b want all 0", out_valid, out_data, out_bits, out_last);
        end
        @(posedge clk); #1 rst = 1'b0;
        drive(T_TAIL, 32'h000000AA); tick();
        total++;
        if ({err_proto, out_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_tail_proto got ep=%b v=%b want 1 0", err_proto, out_valid);
        end
        drive(T_HEADER, hdr(2'd1, 2'd2, 6'd8)); tick();
        drive(T_DATA, 32'h00000099); tick();
        total++;
        if ({out_valid, out_data, out_last} !== {1'b1, 32'h00000099, 1'b0}) begin
            bad++; $display("FAIL reset_next_data got v=%b d=%h l=%b want 1 00000099 0", out_valid, out_data, out_last);
        end
        drive(T_TAIL, 32'h000001C3); tick();
        total++;
        if ({out_valid, out_data, out_bits, out_last} !== {1'b1, 32'h000000C3, 6'd8, 1'b1}) begin
            bad++; $display("FAIL reset_next_tail got v=%b d=%h b=%0d l=%b want 1 000000c3 8 1", out_valid, out_data, out_bits, out_last);
        end
        in_valid = 1'b0; tick();
`ifdef NOC_DEPKT_STATS_EN
        total++;
        if (rx_pkt_count !== 16'd1 || drop_pkt_count !== 16'd0) begin
            bad++; $display("FAIL stats got rx=%0d drop=%0d want 1 0", rx_pkt_count, drop_pkt_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misroute();
        test_proto();
        test_backpressure();
        test_zero_tail();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
